buffered_rr_switch: RTL and testbench

Parametrised input-queued crossbar switch, successor to `very_simple_switch`. Each of `INPUT_QTY` ports carries a valid/ready stream of `DATA_WIDTH`-bit words tagged with a destination index. Words are buffered in per-input FIFOs and delivered to `OUTPUT_QTY` registered output ports. Each output runs its own round-robin arbiter and honours downstream backpressure. It sits between the packet sources and the output consumers, replacing the unbuffered, non-backpressured switch.

---
 rtl/switch_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/buffered_rr_switch.sv | 135 +++++++++++++
 tb/tb_buffered_rr_switch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the crossbar switch family.
// Default sizes match the very_simple_switch benches.
package switch_pkg;

    localparam int SW_INPUT_QTY  = 8;
    localparam int SW_OUTPUT_QTY = 8;
    localparam int SW_DATA_WIDTH = 64;
    localparam int SW_FIFO_DEPTH = 4;
    localparam int SW_MIN_PORTS  = 2;
    localparam int SW_MIN_DEPTH  = 2;

    typedef logic [$clog2(SW_OUTPUT_QTY)-1:0] dest_t;
    typedef logic [$clog2(SW_INPUT_QTY)-1:0]  src_t;

    typedef struct packed {
        dest_t                    dest;
        logic [SW_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// then moves the pointer one past the winner.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         i_req,
    input  logic                 i_en,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_grant_valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_hit;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_hit       = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N))
                w_sum = w_sum - (IW+1)'(N);
            w_idx = w_sum[IW-1:0];
            if (!w_hit && i_req[w_idx]) begin
                w_hit       = 1'b1;
                o_grant_idx = w_idx;
            end
        end
        o_grant_valid = w_hit && i_en;
        if (o_grant_valid)
            o_grant[o_grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_grant_valid) begin
            if (o_grant_idx == IW'(N - 1))
                r_ptr <= '0;
            else
                r_ptr <= o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/buffered_rr_switch.sv
// Input-queued crossbar: per-input FIFOs feeding registered outputs,
// each output with its own round-robin arbiter and backpressure.
module buffered_rr_switch
    import switch_pkg::*;
#(
    parameter int INPUT_QTY  = SW_INPUT_QTY,
    parameter int OUTPUT_QTY = SW_OUTPUT_QTY,
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int FIFO_DEPTH = SW_FIFO_DEPTH
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [INPUT_QTY-1:0]                         data_in_valid,
    output logic [INPUT_QTY-1:0]                         data_in_ready,
    input  logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]         data_in,
    input  logic [INPUT_QTY-1:0][$clog2(OUTPUT_QTY)-1:0] data_in_destination,
    output logic [OUTPUT_QTY-1:0]                        data_out_valid,
    input  logic [OUTPUT_QTY-1:0]                        data_out_ready,
    output logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0]        data_out,
    output logic [OUTPUT_QTY-1:0][$clog2(INPUT_QTY)-1:0] data_out_source
);

    localparam int DW = $clog2(OUTPUT_QTY);
    localparam int SW = $clog2(INPUT_QTY);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DW-1:0]         dest;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [INPUT_QTY-1:0]                 w_full;
    logic [INPUT_QTY-1:0]                 w_empty;
    logic [INPUT_QTY-1:0]                 w_push;
    logic [INPUT_QTY-1:0]                 w_pop;
    logic [INPUT_QTY-1:0]                 w_drop;
    logic [INPUT_QTY-1:0][DW-1:0]         w_head_dest;
    logic [INPUT_QTY-1:0][DATA_WIDTH-1:0] w_head_data;

    logic [OUTPUT_QTY-1:0][INPUT_QTY-1:0] w_req;
    logic [OUTPUT_QTY-1:0][INPUT_QTY-1:0] w_gnt;
    logic [OUTPUT_QTY-1:0][SW-1:0]        w_gnt_idx;
    logic [OUTPUT_QTY-1:0]                w_gnt_vld;
    logic [OUTPUT_QTY-1:0]                w_can_load;

    for (genvar i = 0; i < INPUT_QTY; i++) begin : g_fifo
        entry_t        r_mem [FIFO_DEPTH];
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic [PW:0]   r_count;

        assign w_full[i]        = (r_count == (PW+1)'(FIFO_DEPTH));
        assign w_empty[i]       = (r_count == '0);
        assign data_in_ready[i] = !w_full[i] && !reset;
        assign w_push[i]        = data_in_valid[i] && data_in_ready[i];
        assign w_head_dest[i]   = r_mem[r_rptr].dest;
        assign w_head_data[i]   = r_mem[r_rptr].data;
        // Unreachable destinations are flushed so they cannot block the queue.
        assign w_drop[i] = !w_empty[i]
                        && (32'(w_head_dest[i]) >= OUTPUT_QTY);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[i])
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop[i])
                    r_rptr <= r_rptr + 1'b1;
                if (w_push[i] && !w_pop[i])
                    r_count <= r_count + 1'b1;
                else if (!w_push[i] && w_pop[i])
                    r_count <= r_count - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[i])
                r_mem[r_wptr] <= '{dest: data_in_destination[i],
                                   data: data_in[i]};
        end
    end

    always_comb begin
        w_pop = w_drop;
        for (int k = 0; k < OUTPUT_QTY; k++)
            w_pop = w_pop | w_gnt[k];
    end

    for (genvar o = 0; o < OUTPUT_QTY; o++) begin : g_out
        logic                  r_vld;
        logic [DATA_WIDTH-1:0] r_data;
        logic [SW-1:0]         r_src;

        for (genvar i = 0; i < INPUT_QTY; i++) begin : g_req
            assign w_req[o][i] = !w_empty[i]
                              && (32'(w_head_dest[i]) == o);
        end

        assign w_can_load[o] = !r_vld || data_out_ready[o];

        rr_arbiter #(
            .N(INPUT_QTY)
        ) u_arb (
            .clk          (clk),
            .reset        (reset),
            .i_req        (w_req[o]),
            .i_en         (w_can_load[o]),
            .o_grant      (w_gnt[o]),
            .o_grant_idx  (w_gnt_idx[o]),
            .o_grant_valid(w_gnt_vld[o])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_src  <= '0;
            end else if (w_gnt_vld[o]) begin
                r_vld  <= 1'b1;
                r_data <= w_head_data[w_gnt_idx[o]];
                r_src  <= w_gnt_idx[o];
            end else if (data_out_ready[o]) begin
                r_vld <= 1'b0;
            end
        end

        assign data_out_valid[o]  = r_vld;
        assign data_out[o]        = r_data;
        assign data_out_source[o] = r_src;
    end

endmodule

// File: tb/tb_buffered_rr_switch.sv
// Directed bench for buffered_rr_switch at default sizes.
module tb_buffered_rr_switch;

    localparam int NI = 8;
    localparam int NO = 8;
    localparam int DW = 64;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NI-1:0]          data_in_valid;
    logic [NI-1:0]          data_in_ready;
    logic [NI-1:0][DW-1:0]  data_in;
    logic [NI-1:0][2:0]     data_in_destination;
    logic [NO-1:0]          data_out_valid;
    logic [NO-1:0]          data_out_ready;
    logic [NO-1:0][DW-1:0]  data_out;
    logic [NO-1:0][2:0]     data_out_source;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    buffered_rr_switch dut (
        .clk                (clk),
        .reset              (reset),
        .data_in_valid      (data_in_valid),
        .data_in_ready      (data_in_ready),
        .data_in            (data_in),
        .data_in_destination(data_in_destination),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready),
        .data_out           (data_out),
        .data_out_source    (data_out_source)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst_to1(input logic [63:0] base);
        tick();
        for (int i = 0; i < NI; i++) begin
            data_in[i]             = base + 64'(i);
            data_in_destination[i] = 3'd1;
        end
        data_in_valid = '1;
        tick();
        data_in_valid = '0;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            @(negedge clk);
            check("cont_valid", 64'(data_out_valid[1]), 64'd1);
            check("cont_data", data_out[1], base + 64'(k));
        end
        @(negedge clk);
        check("cont_idle", 64'(data_out_valid[1]), 64'd0);
    endtask

    task automatic pair_to1(input logic [63:0] d0, input logic [63:0] d5,
                            input logic [63:0] first_src);
        tick();
        data_in[0] = d0;
        data_in[5] = d5;
        data_in_destination[0] = 3'd1;
        data_in_destination[5] = 3'd1;
        data_in_valid = 8'b0010_0001;
        tick();
        data_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("rr_first_src", 64'(data_out_source[1]), first_src);
        check("rr_first_data", data_out[1],
              (first_src == 64'd0) ? d0 : d5);
        @(negedge clk);
        check("rr_second_data", data_out[1],
              (first_src == 64'd0) ? d5 : d0);
    endtask

    initial begin
        int got;
        int seen;
        logic acc6;

        data_out_ready = '1;
        data_in_valid  = '1;
        for (int i = 0; i < NI; i++) begin
            data_in[i]             = 64'(i + 1);
            data_in_destination[i] = 3'(i);
        end

        repeat (3) begin
            @(negedge clk);
            check("rst_ovalid", 64'(data_out_valid), 64'd0);
            check("rst_iready", 64'(data_in_ready), 64'd0);
            check("rst_odata", 64'(|data_out), 64'd0);
            check("rst_osrc", 64'(|data_out_source), 64'd0);
        end
        @(posedge clk);
        #1;
        data_in_valid = '0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(data_in_ready), 64'hFF);

        tick();
        data_in[2]             = 64'hA5;
        data_in_destination[2] = 3'd5;
        data_in_valid          = 8'b0000_0100;
        tick();
        data_in_valid = '0;
        @(negedge clk);
        check("single_nobypass", 64'(data_out_valid), 64'd0);
        @(negedge clk);
        check("single_valid", 64'(data_out_valid), 64'h20);
        check("single_data", data_out[5], 64'hA5);
        check("single_src", 64'(data_out_source[5]), 64'd2);
        @(negedge clk);
        check("single_drain", 64'(data_out_valid), 64'd0);
        check("single_hold", data_out[5], 64'hA5);

        burst_to1(64'd0);
        burst_to1(64'd8);

        tick();
        data_in[3]             = 64'h33;
        data_in_destination[3] = 3'd1;
        data_in_valid          = 8'b0000_1000;
        tick();
        data_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("rr_solo", data_out[1], 64'h33);
        pair_to1(64'h100, 64'h105, 64'd5);

        tick();
        data_out_ready[3]      = 1'b0;
        data_in_destination[0] = 3'd3;
        for (int w = 1; w <= 5; w++) begin
            data_in[0]       = 64'(w);
            data_in_valid[0] = 1'b1;
            tick();
        end
        data_in[0] = 64'd6;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(data_in_ready[0]), 64'd0);
            check("bp_out_valid", 64'(data_out_valid[3]), 64'd1);
            check("bp_hold", data_out[3], 64'd1);
            check("bp_hold_src", 64'(data_out_source[3]), 64'd0);
        end
        @(posedge clk);
        #1;
        data_out_ready[3] = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            @(negedge clk);
            acc6 = data_in_valid[0] && data_in_ready[0];
            if (data_out_valid[3]) begin
                got++;
                check("bp_order", data_out[3], 64'(got));
            end
            @(posedge clk);
            #1;
            if (acc6)
                data_in_valid[0] = 1'b0;
        end
        check("bp_count", 64'(got), 64'd6);
        check("bp_in_done", 64'(data_in_valid[0]), 64'd0);

        repeat (3) tick();
        for (int i = 0; i < NI; i++)
            data_in_destination[i] = 3'(i);
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                for (int i = 0; i < NI; i++)
                    data_in[i] = 64'(c * 256 + i);
                data_in_valid = '1;
            end else begin
                data_in_valid = '0;
            end
            @(negedge clk);
            if (c >= 2) begin
                check("par_valid", 64'(data_out_valid), 64'hFF);
                for (int i = 0; i < NO; i++) begin
                    check("par_data", data_out[i], 64'((c - 2) * 256 + i));
                    check("par_src", 64'(data_out_source[i]), 64'(i));
                end
            end
            @(posedge clk);
            #1;
        end

        repeat (2) tick();
        data_out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            data_in[i]             = 64'(8'hF0 + i);
            data_in_destination[i] = 3'd6;
        end
        data_in[4]             = 64'hE4;
        data_in_destination[4] = 3'd2;
        data_in_valid          = 8'h1F;
        tick();
        tick();
        data_in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_pre_valid", 64'(data_out_valid), 64'h44);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_valid", 64'(data_out_valid), 64'd0);
        check("mrst_data", 64'(|data_out), 64'd0);
        check("mrst_iready", 64'(data_in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        data_out_ready = '1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_out_valid != '0)
                seen++;
        end
        check("mrst_stale", 64'(seen), 64'd0);
        pair_to1(64'h200, 64'h205, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
